// File: rtl/arith_pkg.sv
// Shared arithmetic constants and types for the multi-cycle divide unit.
// No logic; types and parameters only.
// Not applicable (package).
package arith_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/rcs_8bit.sv
// 8-bit ripple-carry subtractor: diff = a - b, carry_out = 1 when a >= b (no borrow).
// Latency: purely combinational.
// Backpressure: none, no handshake.
module rcs_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       carry_out
);

  // a - b is formed as a + ~b + 1, so the chain starts with carry-in set.
  logic [8:0] w_c;
  logic [7:0] w_nb;

  assign w_nb   = ~b;
  assign w_c[0] = 1'b1;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign diff[i]   = a[i] ^ w_nb[i] ^ w_c[i];
    assign w_c[i+1]  = (a[i] & w_nb[i]) | (a[i] & w_c[i]) | (w_nb[i] & w_c[i]);
  end

  assign carry_out = w_c[8];

endmodule

// File: rtl/seq_divider_8bit.sv
// Unsigned restoring divider producing one quotient bit per clock via rcs_8bit.
// Latency: done pulses WIDTH+1 cycles after the accepting start (1 cycle for divide-by-zero).
// Backpressure: start is ignored while busy; results hold until the next completion or reset.
module seq_divider_8bit
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // The trial subtractor is a fixed 8-bit block, so no other width can be built.
  if (WIDTH != DIV_WIDTH) begin : g_bad_width
    $error("seq_divider_8bit: WIDTH must be %0d", DIV_WIDTH);
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  div_state_t       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_diff;
  logic             w_carry;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_accept;
  logic             w_last;

  // Partial remainder shifted left with the next dividend bit; R < D keeps it within WIDTH bits.
  assign w_p = {r_r[WIDTH-2:0], r_q[WIDTH-1]};

  rcs_8bit u_sub (
    .a        (w_p),
    .b        (r_d),
    .diff     (w_diff),
    .carry_out(w_carry)
  );

  assign w_r_next = w_carry ? w_diff : w_p;
  assign w_q_next = {r_q[WIDTH-2:0], w_carry};
  assign w_accept = (r_state != RUN) && start;
  assign w_last   = (r_cnt == LAST_CNT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_next_state = (divisor == '0) ? DONE : RUN;
        else       w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture, per-bit iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_q   <= dividend;
      r_d   <= divisor;
      r_r   <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
      // Divide-by-zero completes immediately with the conventional all-ones quotient.
      if (divisor == '0) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
        r_dbz       <= 1'b1;
      end
    end else if (r_state == RUN) begin
      r_q   <= w_q_next;
      r_r   <= w_r_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_r_next;
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Self-checking bench for seq_divider_8bit with directed cases and a random sweep.
// Reference results come from plain integer division.
// Outputs are sampled on the falling clock edge.
module tb_seq_divider_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_divider_8bit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Present a request in the low phase and drop start right after the sampling edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count falling edges until done; busy must be high on every earlier one.
  task automatic wait_done(input string tag, input int lat);
    int  n;
    logic seen;
    int  busy_bad;
    seen     = 1'b0;
    busy_bad = 0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_busy_while_run"}, 32'(busy_bad), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq, er;
    logic       ez;
    if (b == 8'd0) begin
      eq = 8'hFF; er = a; ez = 1'b1;
    end else begin
      eq = a / b; er = a % b; ez = 1'b0;
    end
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_r"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
  endtask

  // Full single operation: request, latency, result, one-cycle done.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b);
    issue(a, b);
    wait_done(tag, (b == 8'd0) ? 1 : 9);
    check_result(tag, a, b);
    @(negedge clk);
    chk({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [7:0] a, b;
    int         saw_done;
    int         busy_seen;
    rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    // Basic operations and hold behaviour.
    do_op("d200_7", 8'd200, 8'd7);
    chk("d200_7_exact_q", 32'(quotient), 32'd28);
    chk("d200_7_exact_r", 32'(remainder), 32'd4);
    do_op("d255_1", 8'd255, 8'd1);
    do_op("d100_200", 8'd100, 8'd200);
    dividend = 8'd9; divisor = 8'd9;
    repeat (4) @(negedge clk);
    chk("hold_q", 32'(quotient), 32'd0);
    chk("hold_r", 32'(remainder), 32'd100);

    // Divide by zero: immediate completion, never busy.
    issue(8'd77, 8'd0);
    @(negedge clk);
    chk("dz_done", 32'(done), 32'd1);
    chk("dz_busy", 32'(busy), 32'd0);
    check_result("dz", 8'd77, 8'd0);
    @(negedge clk);
    chk("dz_done_width", 32'(done), 32'd0);
    chk("dz_busy_after", 32'(busy), 32'd0);

    // Start during RUN is ignored; start in DONE is accepted back-to-back.
    issue(8'd50, 8'd25);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd99; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", 6);
    check_result("ign", 8'd50, 8'd25);
    start = 1'b1; dividend = 8'd99; divisor = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("b2b", 9);
    check_result("b2b", 8'd99, 8'd3);

    // Reset in the middle of an operation aborts it cleanly.
    issue(8'd15, 8'd10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_q", 32'(quotient), 32'd0);
    chk("mid_rst_r", 32'(remainder), 32'd0);
    chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    saw_done  = 0;
    busy_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done++;
      if (busy) busy_seen++;
    end
    chk("mid_rst_no_done", 32'(saw_done), 32'd0);
    chk("mid_rst_no_busy", 32'(busy_seen), 32'd0);
    do_op("after_rst", 8'd15, 8'd10);

    // Random sweep against integer arithmetic.
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      do_op("rnd", a, b);
      if (b != 8'd0) begin
        chk("rnd_ident", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        chk("rnd_rem_lt", 32'(remainder < b), 32'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
